apu_resp_router: RTL

APU_RESP_ROUTER -- requirements
Module: apu_resp_router

---
 rtl/fpu_interco_pkg.sv | 14 +
 rtl/apu_tag_fifo.sv | 55 +++++
 rtl/apu_resp_router.sv | 97 +++++++++
 3 files changed

// File: rtl/fpu_interco_pkg.sv
// Shared types and default widths for the APU response routing path.
package fpu_interco_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 32;
  localparam int unsigned RFLAG_WIDTH_DEF = 6;
  localparam int unsigned DEPTH_DEF       = 4;

  // Response payload at the default widths.
  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0]  rdata;
    logic [RFLAG_WIDTH_DEF-1:0] flag;
  } resp_t;

endpackage

// File: rtl/apu_tag_fifo.sv
// In-order tag FIFO holding the one-hot ID of every operation in flight.
// Power-of-two depth, so the pointers wrap by natural overflow.
module apu_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Tag storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apu_resp_router.sv
// Routes in-order FPU results back to the requesting core by one-hot ID.
// Optional macro APU_RESP_ROUTER_ID_CHECK_EN: reject non-one-hot request
// IDs (granted but not forwarded) and flag them on err_o.
module apu_resp_router
  import fpu_interco_pkg::*;
#(
  parameter int unsigned NB_CORES    = 8,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned RFLAG_WIDTH = RFLAG_WIDTH_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic [NB_CORES-1:0]    id_i,
  output logic                   gnt_o,
  output logic                   fpu_req_o,
  input  logic                   fpu_gnt_i,
  input  logic                   fpu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]  fpu_rdata_i,
  input  logic [RFLAG_WIDTH-1:0] fpu_rflag_i,
  output logic [NB_CORES-1:0]    resp_valid_o,
  output logic [DATA_WIDTH-1:0]  resp_rdata_o,
  output logic [RFLAG_WIDTH-1:0] resp_flag_o,
  output logic                   apu_status_o,
  output logic                   err_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  rdata;
    logic [RFLAG_WIDTH-1:0] flag;
  } resp_w_t;

  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic [NB_CORES-1:0]    head_id;
  logic                   id_ok;
  logic                   id_bad;
  logic                   push;
  logic                   pop;
  logic                   orphan;
  resp_w_t                resp_q;

`ifdef APU_RESP_ROUTER_ID_CHECK_EN
  assign id_ok  = (id_i != '0) && ((id_i & (id_i - 1'b1)) == '0);
  assign id_bad = req_i & ~full & ~id_ok;
`else
  assign id_ok  = 1'b1;
  assign id_bad = 1'b0;
`endif

  // Full blocks acceptance outright; a same-cycle pop does not free a slot.
  assign fpu_req_o = req_i & ~full & id_ok;
  assign push      = fpu_req_o & fpu_gnt_i;
  // A bad ID is acknowledged to the core so it does not stall, but never issued.
  assign gnt_o     = push | id_bad;
  assign pop       = fpu_rvalid_i & ~empty;
  assign orphan    = fpu_rvalid_i & empty;

  assign apu_status_o = ~empty;
  assign resp_rdata_o = resp_q.rdata;
  assign resp_flag_o  = resp_q.flag;

  apu_tag_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (NB_CORES)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (id_i),
    .pop       (pop),
    .pop_data  (head_id),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Response register: one-cycle valid pulse, payload held between pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_o <= '0;
      resp_q       <= '0;
    end else begin
      resp_valid_o <= pop ? head_id : '0;
      if (pop) resp_q <= '{rdata: fpu_rdata_i, flag: fpu_rflag_i};
    end
  end

  // Sticky protocol error: orphan results and rejected IDs.
  always_ff @(posedge clk) begin
    if (rst) err_o <= 1'b0;
    else if (orphan | id_bad) err_o <= 1'b1;
  end

endmodule
